// File: rtl/multicore_pkg.sv
// Shared pipeline types: opcode encoding, NOOP word and per-opcode register usage.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package multicore_pkg;

  localparam int INST_SIZE = 32;

  // ADDI x0, x0, 0
  localparam logic [INST_SIZE-1:0] NOOP_CODE = 32'h0000_0013;

  typedef enum logic [6:0] {
    LUI      = 7'b0110111,
    AUIPC    = 7'b0010111,
    JAL      = 7'b1101111,
    JALR     = 7'b1100111,
    BRANCHES = 7'b1100011,
    LOADS    = 7'b0000011,
    STORES   = 7'b0100011,
    ALC_I    = 7'b0010011,
    ALC_R    = 7'b0110011,
    SYNCH    = 7'b0001111
  } t_opcode;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } t_usage;

  // Register usage of an opcode; anything unrecognised behaves like ALC_I.
  // The rd = x0 exception is applied by the caller, which owns the rd field.
  function automatic t_usage opcode_usage(input logic [6:0] op);
    t_usage u;
    u.uses_rs1  = 1'b1;
    u.uses_rs2  = 1'b0;
    u.writes_rd = 1'b1;
    case (op)
      LUI, AUIPC, JAL: u.uses_rs1 = 1'b0;
      ALC_R:           u.uses_rs2 = 1'b1;
      STORES, BRANCHES: begin
        u.uses_rs2  = 1'b1;
        u.writes_rd = 1'b0;
      end
      SYNCH:           u.writes_rd = 1'b0;
      default:         ;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/regfile_mwp.sv
// Multi-write-port register file with two bypassed combinational read ports.
// Latency: writes land on the next edge; reads see same-cycle write-back data.
// Backpressure: none, every enabled write commits.
module regfile_mwp #(
  parameter int DATA_SIZE    = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_WB_PORTS = 2
) (
  input  logic                                              i_aclk,
  input  logic                                              i_areset_n,
  input  logic [NUM_WB_PORTS-1:0]                           i_wb_en,
  input  logic [NUM_WB_PORTS-1:0][$clog2(NUM_REGS)-1:0]     i_wb_addr,
  input  logic [NUM_WB_PORTS-1:0][DATA_SIZE-1:0]            i_wb_data,
  input  logic [$clog2(NUM_REGS)-1:0]                       i_raddr1,
  input  logic [$clog2(NUM_REGS)-1:0]                       i_raddr2,
  output logic [DATA_SIZE-1:0]                              o_rdata1,
  output logic [DATA_SIZE-1:0]                              o_rdata2
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_SIZE-1:0] mem_q [NUM_REGS];
  logic [DATA_SIZE-1:0] mem_d [NUM_REGS];
  logic [AW-1:0]        raddr [2];
  logic [DATA_SIZE-1:0] rdata [2];

  assign raddr[0] = i_raddr1;
  assign raddr[1] = i_raddr2;
  assign o_rdata1 = rdata[0];
  assign o_rdata2 = rdata[1];

  // Apply write-back ports in ascending order so the highest index wins a collision.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (i_wb_en[p] && (i_wb_addr[p] != '0)) begin
        mem_d[i_wb_addr[p]] = i_wb_data[p];
      end
    end
    mem_d[0] = '0;
  end

  // Storage array, cleared on reset.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read with bypass: highest-index matching write-back port overrides storage; x0 reads 0.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rdata[k] = mem_q[raddr[k]];
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (i_wb_en[p] && (i_wb_addr[p] == raddr[k])) begin
          rdata[k] = i_wb_data[p];
        end
      end
      if (raddr[k] == '0) begin
        rdata[k] = '0;
      end
    end
  end

endmodule

// File: rtl/decode_regread_sb.sv
// Decode/register-read stage: holds one instruction, reads operands, interlocks on a scoreboard.
// Latency: 1 cycle fetch to o_valid minimum; 1 instruction/cycle throughput.
// Backpressure: o_ready drops while the held instruction cannot leave; o_valid waits on hazards.
module decode_regread_sb
  import multicore_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_WB_PORTS = 2,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                                          i_aclk,
  input  logic                                          i_areset_n,
  input  logic                                          i_valid,
  output logic                                          o_ready,
  input  logic [INST_SIZE-1:0]                          i_instruction,
  input  logic [31:0]                                   i_pc,
  output logic                                          o_valid,
  input  logic                                          i_ready,
  output logic [INST_SIZE-1:0]                          o_instruction,
  output logic [31:0]                                   o_pc,
  output logic [$clog2(NUM_REGS)-1:0]                   o_rs1,
  output logic [$clog2(NUM_REGS)-1:0]                   o_rs2,
  output logic [$clog2(NUM_REGS)-1:0]                   o_rdest,
  output logic [DATA_SIZE-1:0]                          o_rd1,
  output logic [DATA_SIZE-1:0]                          o_rd2,
  input  logic [NUM_WB_PORTS-1:0]                       i_wb_en,
  input  logic [NUM_WB_PORTS-1:0][$clog2(NUM_REGS)-1:0] i_wb_addr,
  input  logic [NUM_WB_PORTS-1:0][DATA_SIZE-1:0]        i_wb_data,
  input  logic                                          i_sb_release_en,
  input  logic [$clog2(NUM_REGS)-1:0]                   i_sb_release_addr,
  input  logic                                          i_flush,
  output logic [STALL_CNT_W-1:0]                        o_stall_cnt
);

  localparam int AW = $clog2(NUM_REGS);

  logic                   held_valid_q, held_valid_d;
  logic [INST_SIZE-1:0]   instr_q, instr_d;
  logic [31:0]            pc_q, pc_d;
  logic [NUM_REGS-1:0]    sb_q, sb_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [NUM_REGS-1:0]    clear_now;
  logic [NUM_REGS-1:0]    busy;
  logic [AW-1:0]          rs1, rs2, rd;
  t_usage                 usage;
  logic                   writes_rd;
  logic                   hazard;
  logic                   fire;
  logic                   capture;

  assign rs1       = instr_q[15 +: AW];
  assign rs2       = instr_q[20 +: AW];
  assign rd        = instr_q[7 +: AW];
  assign usage     = opcode_usage(instr_q[6:0]);
  assign writes_rd = usage.writes_rd & (rd != '0);

  // Registers being written back or released this cycle stop blocking immediately.
  always_comb begin
    clear_now = '0;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (i_wb_en[p]) begin
        clear_now[i_wb_addr[p]] = 1'b1;
      end
    end
    if (i_sb_release_en) begin
      clear_now[i_sb_release_addr] = 1'b1;
    end
  end

  assign busy   = sb_q & ~clear_now;
  assign hazard = (usage.uses_rs1 & busy[rs1])
                | (usage.uses_rs2 & busy[rs2])
                | (writes_rd      & busy[rd]);

  // o_valid is a function of held state and write-back inputs only, never of i_ready.
  assign o_valid = held_valid_q & ~hazard;
  assign fire    = o_valid & i_ready;
  assign o_ready = ~i_flush & (~held_valid_q | fire);
  assign capture = i_valid & o_ready;

  // Hold register: flush empties it, otherwise capture refills it or fire drains it.
  always_comb begin
    held_valid_d = held_valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    if (i_flush) begin
      held_valid_d = 1'b0;
      instr_d      = NOOP_CODE;
    end else if (capture) begin
      held_valid_d = 1'b1;
      instr_d      = i_instruction;
      pc_d         = i_pc;
    end else if (fire) begin
      held_valid_d = 1'b0;
    end
  end

  // Scoreboard: clears first, then the issuing instruction's rd is claimed; flush wipes all.
  always_comb begin
    sb_d = sb_q & ~clear_now;
    if (fire && writes_rd) begin
      sb_d[rd] = 1'b1;
    end
    if (i_flush) begin
      sb_d = '0;
    end
    sb_d[0] = 1'b0;
  end

  // Saturating count of cycles an instruction is held back by a hazard.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (held_valid_q && !o_valid && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stage state registers.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      held_valid_q <= 1'b0;
      instr_q      <= NOOP_CODE;
      pc_q         <= '0;
      sb_q         <= '0;
      stall_cnt_q  <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      sb_q         <= sb_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  regfile_mwp #(
    .DATA_SIZE    (DATA_SIZE),
    .NUM_REGS     (NUM_REGS),
    .NUM_WB_PORTS (NUM_WB_PORTS)
  ) u_regfile (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_wb_en    (i_wb_en),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .i_raddr1   (rs1),
    .i_raddr2   (rs2),
    .o_rdata1   (o_rd1),
    .o_rdata2   (o_rd2)
  );

  assign o_instruction = instr_q;
  assign o_pc          = pc_q;
  assign o_rs1         = rs1;
  assign o_rs2         = rs2;
  assign o_rdest       = rd;
  assign o_stall_cnt   = stall_cnt_q;

endmodule
